// File: rtl/prefetch_fetcher.sv
// Code-fetch responder: reads the quadword enclosing the prefetch address as a
// two-beat burst, aligns the useful bytes and posts one entry to the prefetch FIFO.
module prefetch_fetcher (
  input  logic        clk,
  input  logic        rst,
  input  logic        pr_reset,
  input  logic [31:0] prefetch_address,
  input  logic [4:0]  prefetch_length,
  input  logic        prefetch_su,
  output logic        prefetched_do,
  output logic [4:0]  prefetched_length,
  input  logic        prefetchfifo_full,
  output logic        prefetchfifo_accept_do,
  output logic [67:0] prefetchfifo_accept_data,
  output logic        mem_read_do,
  output logic [31:0] mem_read_address,
  output logic        mem_read_su,
  input  logic        mem_read_accept,
  input  logic        mem_read_valid,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BEAT0, S_BEAT1, S_WRITE, S_DRAIN
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  owed, owed_nxt;
  logic [2:0]  off;
  logic [3:0]  len;
  logic [31:0] lo, hi;
  logic        start, store_lo, store_hi;

  // Bytes deliverable before the quadword boundary, capped by the remaining limit.
  function automatic logic [3:0] clip_len(input logic [2:0] o, input logic [4:0] lim);
    logic [4:0] room;
    room = 5'd8 - {2'b00, o};
    clip_len = (lim < room) ? lim[3:0] : room[3:0];
  endfunction

  function automatic logic [63:0] align_bytes(input logic [63:0] qw, input logic [2:0] o);
    align_bytes = qw >> {o, 3'b000};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      owed  <= 2'd0;
    end else begin
      state <= state_nxt;
      owed  <= owed_nxt;
    end
  end

  always_comb begin
    state_nxt              = state;
    owed_nxt               = owed;
    start                  = 1'b0;
    store_lo               = 1'b0;
    store_hi               = 1'b0;
    mem_read_do            = 1'b0;
    prefetched_do          = 1'b0;
    prefetchfifo_accept_do = 1'b0;
    case (state)
      S_IDLE: begin
        if (!pr_reset && (prefetch_length != 5'd0) && !prefetchfifo_full) begin
          start     = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_read_do = 1'b1;
        if (pr_reset) begin
          if (mem_read_accept) begin
            state_nxt = S_DRAIN;
            owed_nxt  = 2'd2;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (mem_read_accept) begin
          state_nxt = S_BEAT0;
        end
      end
      S_BEAT0: begin
        if (pr_reset) begin
          state_nxt = S_DRAIN;
          owed_nxt  = mem_read_valid ? 2'd1 : 2'd2;
        end else if (mem_read_valid) begin
          store_lo  = 1'b1;
          state_nxt = S_BEAT1;
        end
      end
      S_BEAT1: begin
        if (pr_reset) begin
          state_nxt = mem_read_valid ? S_IDLE : S_DRAIN;
          owed_nxt  = 2'd1;
        end else if (mem_read_valid) begin
          store_hi  = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        state_nxt = S_IDLE;
        if (!pr_reset) begin
          prefetched_do          = 1'b1;
          prefetchfifo_accept_do = 1'b1;
        end
      end
      S_DRAIN: begin
        // Abandoned burst: swallow the beats memory still owes us.
        if (mem_read_valid) begin
          owed_nxt = owed - 2'd1;
          if (owed == 2'd1) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off              <= 3'd0;
      len              <= 4'd0;
      mem_read_address <= 32'd0;
      mem_read_su      <= 1'b0;
      lo               <= 32'd0;
      hi               <= 32'd0;
    end else begin
      if (start) begin
        off              <= prefetch_address[2:0];
        len              <= clip_len(prefetch_address[2:0], prefetch_length);
        mem_read_address <= {prefetch_address[31:3], 3'b000};
        mem_read_su      <= prefetch_su;
      end
      if (store_lo) lo <= mem_read_data;
      if (store_hi) hi <= mem_read_data;
    end
  end

  assign prefetched_length        = prefetched_do ? {1'b0, len} : 5'd0;
  assign prefetchfifo_accept_data = {len, align_bytes({hi, lo}, off)};

endmodule

// File: tb/tb_prefetch_fetcher.sv
// Directed bench for prefetch_fetcher; the bench plays the memory side cycle by cycle.
module tb_prefetch_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        pr_reset;
  logic [31:0] prefetch_address;
  logic [4:0]  prefetch_length;
  logic        prefetch_su;
  logic        prefetched_do;
  logic [4:0]  prefetched_length;
  logic        prefetchfifo_full;
  logic        prefetchfifo_accept_do;
  logic [67:0] prefetchfifo_accept_data;
  logic        mem_read_do;
  logic [31:0] mem_read_address;
  logic        mem_read_su;
  logic        mem_read_accept;
  logic        mem_read_valid;
  logic [31:0] mem_read_data;

  int tests_run    = 0;
  int tests_failed = 0;

  prefetch_fetcher dut (
    .clk                      (clk),
    .rst                      (rst),
    .pr_reset                 (pr_reset),
    .prefetch_address         (prefetch_address),
    .prefetch_length          (prefetch_length),
    .prefetch_su              (prefetch_su),
    .prefetched_do            (prefetched_do),
    .prefetched_length        (prefetched_length),
    .prefetchfifo_full        (prefetchfifo_full),
    .prefetchfifo_accept_do   (prefetchfifo_accept_do),
    .prefetchfifo_accept_data (prefetchfifo_accept_data),
    .mem_read_do              (mem_read_do),
    .mem_read_address         (mem_read_address),
    .mem_read_su              (mem_read_su),
    .mem_read_accept          (mem_read_accept),
    .mem_read_valid           (mem_read_valid),
    .mem_read_data            (mem_read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1ns after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (still before the falling edge).
  task automatic settle();
    #3;
  endtask

  // Memory side: accept in the current REQ cycle, then two back-to-back beats.
  // Returns at the drive point of the WRITE cycle.
  task automatic run_burst(input logic [31:0] lo_w, input logic [31:0] hi_w);
    mem_read_accept = 1'b1;
    step();
    mem_read_accept = 1'b0;
    mem_read_valid  = 1'b1;
    mem_read_data   = lo_w;
    step();
    mem_read_data   = hi_w;
    step();
    mem_read_valid  = 1'b0;
    mem_read_data   = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pr_reset = 1'b0; prefetch_address = 32'd0; prefetch_length = 5'd0;
    prefetch_su = 1'b0; prefetchfifo_full = 1'b0; mem_read_accept = 1'b0;
    mem_read_valid = 1'b0; mem_read_data = 32'd0;
    #2;
    tests_run++;
    if (mem_read_do !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_read_do: got %b want 0", mem_read_do); end
    tests_run++;
    if (prefetched_do !== 1'b0 || prefetchfifo_accept_do !== 1'b0) begin
      tests_failed++; $display("FAIL reset_strobes: got %b%b want 00", prefetched_do, prefetchfifo_accept_do);
    end
    tests_run++;
    if (prefetchfifo_accept_data !== 68'd0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", prefetchfifo_accept_data); end
    tests_run++;
    if (mem_read_address !== 32'd0 || mem_read_su !== 1'b0 || prefetched_length !== 5'd0) begin
      tests_failed++; $display("FAIL reset_regs: got addr %h su %b len %0d want 0", mem_read_address, mem_read_su, prefetched_length);
    end
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_aligned();
    prefetch_address = 32'h0000_1000; prefetch_length = 5'd16; prefetch_su = 1'b0;
    step();
    prefetch_length = 5'd0;
    settle();
    tests_run++;
    if (mem_read_do !== 1'b1) begin tests_failed++; $display("FAIL aligned_req: got %b want 1", mem_read_do); end
    tests_run++;
    if (mem_read_address !== 32'h0000_1000) begin tests_failed++; $display("FAIL aligned_addr: got %h want 00001000", mem_read_address); end
    run_burst(32'h4433_2211, 32'h8877_6655);
    settle();
    tests_run++;
    if (prefetched_do !== 1'b1 || prefetchfifo_accept_do !== 1'b1) begin
      tests_failed++; $display("FAIL aligned_strobes: got %b%b want 11", prefetched_do, prefetchfifo_accept_do);
    end
    tests_run++;
    if (prefetched_length !== 5'd8) begin tests_failed++; $display("FAIL aligned_len: got %0d want 8", prefetched_length); end
    tests_run++;
    if (prefetchfifo_accept_data !== 68'h8_8877665544332211) begin
      tests_failed++; $display("FAIL aligned_entry: got %h want 88877665544332211", prefetchfifo_accept_data);
    end
    step();
    settle();
    tests_run++;
    if (prefetched_do !== 1'b0 || prefetchfifo_accept_do !== 1'b0) begin
      tests_failed++; $display("FAIL aligned_single_pulse: got %b%b want 00", prefetched_do, prefetchfifo_accept_do);
    end
  endtask

  task automatic test_unaligned();
    prefetch_address = 32'h0000_1005; prefetch_length = 5'd16;
    step();
    prefetch_length = 5'd0;
    settle();
    tests_run++;
    if (mem_read_address !== 32'h0000_1000) begin tests_failed++; $display("FAIL unaligned_addr: got %h want 00001000", mem_read_address); end
    run_burst(32'h4433_2211, 32'h8877_6655);
    settle();
    tests_run++;
    if (prefetched_length !== 5'd3) begin tests_failed++; $display("FAIL unaligned_len: got %0d want 3", prefetched_length); end
    tests_run++;
    if (prefetchfifo_accept_data !== 68'h3_0000000000887766) begin
      tests_failed++; $display("FAIL unaligned_entry: got %h want 30000000000887766", prefetchfifo_accept_data);
    end
    step();
  endtask

  task automatic test_limit_and_idle();
    prefetch_address = 32'h0000_2000; prefetch_length = 5'd2;
    step();
    prefetch_length = 5'd0;
    run_burst(32'h0000_2211, 32'h0000_0000);
    settle();
    tests_run++;
    if (prefetched_length !== 5'd2) begin tests_failed++; $display("FAIL limit_len: got %0d want 2", prefetched_length); end
    tests_run++;
    if (prefetchfifo_accept_data !== 68'h2_0000000000002211) begin
      tests_failed++; $display("FAIL limit_entry: got %h want 20000000000002211", prefetchfifo_accept_data);
    end
    step();
    for (int i = 0; i < 20; i++) begin
      settle();
      tests_run++;
      if (mem_read_do !== 1'b0) begin tests_failed++; $display("FAIL idle_len0 cycle %0d: got %b want 0", i, mem_read_do); end
      step();
    end
  endtask

  task automatic test_backpressure();
    prefetchfifo_full = 1'b1; prefetch_address = 32'h0000_3000; prefetch_length = 5'd16;
    for (int i = 0; i < 10; i++) begin
      settle();
      tests_run++;
      if (mem_read_do !== 1'b0) begin tests_failed++; $display("FAIL full_blocks cycle %0d: got %b want 0", i, mem_read_do); end
      step();
    end
    prefetchfifo_full = 1'b0;
    step();
    prefetch_length = 5'd0;
    settle();
    tests_run++;
    if (mem_read_do !== 1'b1) begin tests_failed++; $display("FAIL full_release: got %b want 1", mem_read_do); end
    run_burst(32'h0403_0201, 32'h0807_0605);
    settle();
    tests_run++;
    if (prefetchfifo_accept_data !== 68'h8_0807060504030201) begin
      tests_failed++; $display("FAIL full_entry: got %h want 80807060504030201", prefetchfifo_accept_data);
    end
    step();
  endtask

  task automatic test_pr_reset_beat0();
    prefetch_address = 32'h0000_4000; prefetch_length = 5'd16;
    step();
    mem_read_accept = 1'b1;
    step();
    mem_read_accept = 1'b0;
    pr_reset = 1'b1;
    prefetch_address = 32'h0000_5008;
    settle();
    tests_run++;
    if (prefetchfifo_accept_do !== 1'b0) begin tests_failed++; $display("FAIL flush_beat0_strobe: got %b want 0", prefetchfifo_accept_do); end
    step();
    pr_reset = 1'b0;
    mem_read_valid = 1'b1; mem_read_data = 32'hDEAD_BEEF;
    settle();
    tests_run++;
    if (mem_read_do !== 1'b0) begin tests_failed++; $display("FAIL drain_first_beat_req: got %b want 0", mem_read_do); end
    step();
    settle();
    tests_run++;
    if (mem_read_do !== 1'b0 || prefetchfifo_accept_do !== 1'b0) begin
      tests_failed++; $display("FAIL drain_second_beat: got req %b strobe %b want 0 0", mem_read_do, prefetchfifo_accept_do);
    end
    step();
    mem_read_valid = 1'b0; mem_read_data = 32'd0;
    settle();
    tests_run++;
    if (mem_read_do !== 1'b0 || prefetchfifo_accept_do !== 1'b0) begin
      tests_failed++; $display("FAIL drain_exit_idle: got req %b strobe %b want 0 0", mem_read_do, prefetchfifo_accept_do);
    end
    step();
    prefetch_length = 5'd0;
    settle();
    tests_run++;
    if (mem_read_do !== 1'b1) begin tests_failed++; $display("FAIL drain_new_req: got %b want 1", mem_read_do); end
    tests_run++;
    if (mem_read_address !== 32'h0000_5008) begin tests_failed++; $display("FAIL drain_new_addr: got %h want 00005008", mem_read_address); end
    run_burst(32'h1111_1111, 32'h2222_2222);
    settle();
    tests_run++;
    if (prefetchfifo_accept_data !== 68'h8_2222222211111111 || prefetchfifo_accept_do !== 1'b1) begin
      tests_failed++; $display("FAIL drain_refetch_entry: got %h strobe %b want 82222222211111111 1", prefetchfifo_accept_data, prefetchfifo_accept_do);
    end
    step();
  endtask

  task automatic test_pr_reset_write();
    prefetch_address = 32'h0000_6000; prefetch_length = 5'd4;
    step();
    prefetch_length = 5'd0;
    run_burst(32'hAAAA_AAAA, 32'hBBBB_BBBB);
    pr_reset = 1'b1;
    settle();
    tests_run++;
    if (prefetched_do !== 1'b0 || prefetchfifo_accept_do !== 1'b0) begin
      tests_failed++; $display("FAIL flush_write_strobes: got %b%b want 00", prefetched_do, prefetchfifo_accept_do);
    end
    step();
    pr_reset = 1'b0;
    settle();
    tests_run++;
    if (prefetched_do !== 1'b0 || mem_read_do !== 1'b0) begin
      tests_failed++; $display("FAIL flush_write_idle: got do %b req %b want 0 0", prefetched_do, mem_read_do);
    end
  endtask

  task automatic test_async_reset();
    step();
    prefetch_address = 32'h0000_7003; prefetch_length = 5'd16; prefetch_su = 1'b1;
    step();
    prefetch_length = 5'd0;
    settle();
    tests_run++;
    if (mem_read_su !== 1'b1 || mem_read_address !== 32'h0000_7000) begin
      tests_failed++; $display("FAIL su_latch: got su %b addr %h want 1 00007000", mem_read_su, mem_read_address);
    end
    mem_read_accept = 1'b1;
    step();
    mem_read_accept = 1'b0;
    mem_read_valid = 1'b1; mem_read_data = 32'h5566_7788;
    step();
    mem_read_valid = 1'b0; mem_read_data = 32'd0;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (mem_read_do !== 1'b0 || mem_read_su !== 1'b0 || mem_read_address !== 32'd0) begin
      tests_failed++; $display("FAIL async_rst_mem: got req %b su %b addr %h want 0 0 0", mem_read_do, mem_read_su, mem_read_address);
    end
    tests_run++;
    if (prefetchfifo_accept_data !== 68'd0 || prefetched_length !== 5'd0) begin
      tests_failed++; $display("FAIL async_rst_data: got %h len %0d want 0 0", prefetchfifo_accept_data, prefetched_length);
    end
    step();
    rst = 1'b0;
    prefetch_address = 32'h0000_8000; prefetch_length = 5'd16; prefetch_su = 1'b0;
    step();
    prefetch_length = 5'd0;
    settle();
    tests_run++;
    if (mem_read_do !== 1'b1 || mem_read_address !== 32'h0000_8000) begin
      tests_failed++; $display("FAIL post_rst_idle: got req %b addr %h want 1 00008000", mem_read_do, mem_read_address);
    end
    run_burst(32'h0D0C_0B0A, 32'h1110_0F0E);
    settle();
    tests_run++;
    if (prefetchfifo_accept_data !== 68'h8_11100F0E0D0C0B0A) begin
      tests_failed++; $display("FAIL post_rst_entry: got %h want 811100F0E0D0C0B0A", prefetchfifo_accept_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_limit_and_idle();
    test_backpressure();
    test_pr_reset_beat0();
    test_pr_reset_write();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
